ipg_req_dispatch: RTL and testbench

- Parametrised successor to the three fixed per-type IPG processors (read-request, write-request, read-response).
- Accepts IPG chunks extracted by the 10G PHY RX path, tagged with a class and byte length, and buffers each class in its own FIFO.
- Merges the FIFOs onto one round-robin arbitrated valid/ready stream toward the TX-side IPG insertion logic.
- Raises a pause output when any class nears full.

---
 rtl/ipg_pkg.sv | 23 ++
 rtl/ipg_class_fifo.sv | 47 ++++
 rtl/ipg_req_dispatch.sv | 159 +++++++++++++++
 tb/tb_ipg_req_dispatch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipg_pkg.sv
// Shared IPG definitions: class encodings, the chunk record used by RX extraction
// and TX insertion, and the chunk legality rule.
package ipg_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int LEN_WIDTH  = 6;

  localparam int IPG_CLS_RREQ  = 0;
  localparam int IPG_CLS_WREQ  = 1;
  localparam int IPG_CLS_RRESP = 2;

  typedef struct packed {
    logic [1:0]            cls;
    logic [LEN_WIDTH-1:0]  len;
    logic [DATA_WIDTH-1:0] data;
  } ipg_chunk_t;

  // A chunk is legal when its class exists and its length is 1..max_len bytes.
  function automatic logic chunk_legal(int cls, int len, int num_class, int max_len);
    return (cls < num_class) && (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/ipg_class_fifo.sv
// Single-clock FIFO for one IPG class. The pointers carry an extra MSB so that
// full and empty can be told apart. A push into a full FIFO is ignored.
module ipg_class_fifo #(
  parameter int WIDTH = 70,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ipg_req_dispatch.sv
// Per-class IPG chunk buffering merged onto one round-robin valid/ready stream.
// Define IPG_DISP_STATS_EN to add saturating accept/drop/error statistics.
module ipg_req_dispatch #(
  parameter int DATA_WIDTH   = 64,
  parameter int LEN_WIDTH    = 6,
  parameter int NUM_CLASS    = 3,
  parameter int FIFO_DEPTH   = 8,
  parameter int PAUSE_THRESH = 6,
  localparam int CLS_WIDTH   = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [CLS_WIDTH-1:0]  rx_class,
  input  logic [LEN_WIDTH-1:0]  rx_len,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CLS_WIDTH-1:0]  out_class,
  output logic [LEN_WIDTH-1:0]  out_len,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  tx_pause,
  output logic                  drop_pulse,
  output logic                  err_pulse
`ifdef IPG_DISP_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [NUM_CLASS*16-1:0] stat_accept,
  output logic [NUM_CLASS*16-1:0] stat_drop,
  output logic [15:0]             stat_err
`endif
);
  import ipg_pkg::*;

  localparam int MAX_LEN = DATA_WIDTH / 8;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int EW      = LEN_WIDTH + DATA_WIDTH;

  logic [NUM_CLASS-1:0] push;
  logic [NUM_CLASS-1:0] pop;
  logic [NUM_CLASS-1:0] full;
  logic [NUM_CLASS-1:0] empty;
  logic [EW-1:0]        rdata [NUM_CLASS];
  logic [CW-1:0]        count [NUM_CLASS];
  logic                 legal;
  logic                 accept;
  logic                 any_ready;
  logic                 load;
  logic                 pause_next;
  logic [CLS_WIDTH-1:0] rr_ptr;
  logic [CLS_WIDTH-1:0] winner;

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_fifo
    ipg_class_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[c]),
      .pop   (pop[c]),
      .wdata ({rx_len, rx_data}),
      .rdata (rdata[c]),
      .full  (full[c]),
      .empty (empty[c]),
      .count (count[c])
    );
  end

  // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  always_comb begin
    legal  = chunk_legal(int'(rx_class), int'(rx_len), NUM_CLASS, MAX_LEN);
    accept = 1'b0;
    push   = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (rx_valid && legal && int'(rx_class) == c && !full[c]) begin
        push[c] = 1'b1;
        accept  = 1'b1;
      end
    end
  end

  always_comb begin
    winner    = rr_ptr;
    any_ready = 1'b0;
    for (int k = 1; k <= NUM_CLASS; k++) begin
      if (!any_ready && !empty[(int'(rr_ptr) + k) % NUM_CLASS]) begin
        any_ready = 1'b1;
        winner    = CLS_WIDTH'((int'(rr_ptr) + k) % NUM_CLASS);
      end
    end
    load = any_ready && (!out_valid || out_ready);
    pop  = '0;
    if (load) pop[winner] = 1'b1;
    pause_next = 1'b0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (int'(count[c]) >= PAUSE_THRESH) pause_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_class  <= '0;
      out_len    <= '0;
      out_data   <= '0;
      rr_ptr     <= CLS_WIDTH'(NUM_CLASS - 1);
      tx_pause   <= 1'b0;
      drop_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      drop_pulse <= rx_valid & ~accept;
      err_pulse  <= rx_valid & ~legal;
      tx_pause   <= pause_next;
      if (load) begin
        out_valid            <= 1'b1;
        out_class            <= winner;
        {out_len, out_data}  <= rdata[winner];
        rr_ptr               <= winner;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef IPG_DISP_STATS_EN
  logic [15:0] acc_cnt [NUM_CLASS];
  logic [15:0] drp_cnt [NUM_CLASS];
  logic [15:0] err_cnt;

  // A drop is charged to its class only when that class exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        acc_cnt[c] <= '0;
        drp_cnt[c] <= '0;
      end
      err_cnt <= '0;
    end else if (stat_clr) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        acc_cnt[c] <= '0;
        drp_cnt[c] <= '0;
      end
      err_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        if (push[c] && acc_cnt[c] != 16'hFFFF) acc_cnt[c] <= acc_cnt[c] + 16'd1;
        if (rx_valid && int'(rx_class) == c && !push[c] && drp_cnt[c] != 16'hFFFF)
          drp_cnt[c] <= drp_cnt[c] + 16'd1;
      end
      if (rx_valid && !legal && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_stat
    assign stat_accept[c*16 +: 16] = acc_cnt[c];
    assign stat_drop[c*16 +: 16]   = drp_cnt[c];
  end
  assign stat_err = err_cnt;
`endif

endmodule

// File: tb/tb_ipg_req_dispatch.sv
// Self-checking bench for ipg_req_dispatch: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_ipg_req_dispatch;
  import ipg_pkg::*;

  localparam int NC     = 3;
  localparam int DEPTH  = 8;
  localparam int THRESH = 6;
  localparam int MAXLEN = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [1:0]  rx_class = '0;
  logic [5:0]  rx_len = '0;
  logic [63:0] rx_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [1:0]  out_class;
  logic [5:0]  out_len;
  logic [63:0] out_data;
  logic        tx_pause;
  logic        drop_pulse;
  logic        err_pulse;
`ifdef IPG_DISP_STATS_EN
  logic        stat_clr = 1'b0;
  logic [47:0] stat_accept;
  logic [47:0] stat_drop;
  logic [15:0] stat_err;
`endif

  int checks = 0;
  int passes = 0;

  ipg_req_dispatch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_class   (rx_class),
    .rx_len     (rx_len),
    .rx_data    (rx_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_len    (out_len),
    .out_data   (out_data),
    .tx_pause   (tx_pause),
    .drop_pulse (drop_pulse),
    .err_pulse  (err_pulse)
`ifdef IPG_DISP_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_accept (stat_accept),
    .stat_drop   (stat_drop),
    .stat_err    (stat_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: one queue per class plus the visible output slot.
  logic [69:0] mq [NC][$];
  bit          m_ov;
  bit          m_pause;
  bit          m_drop;
  bit          m_err;
  int          m_oc;
  int          m_rr;
  logic [5:0]  m_ol;
  logic [63:0] m_od;

  typedef struct {
    logic        v;
    int          c;
    int          l;
    logic [63:0] d;
    logic        r;
    logic        e_ov;
    int          e_cls;
    int          e_len;
    logic [63:0] e_data;
    logic        e_drop;
    logic        e_err;
  } vec_t;

  vec_t tbl [9];
  int   rrExp [5];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    for (int i = 0; i < NC; i++) mq[i].delete();
    m_ov = 0; m_pause = 0; m_drop = 0; m_err = 0;
    m_oc = 0; m_rr = NC - 1; m_ol = '0; m_od = '0;
  endtask

  // Applies one clock edge worth of the dispatch rules to the model.
  task automatic modelStep(input logic v, input int c, input int l, input logic [63:0] d, input logic r);
    int  n [NC];
    bit  legalc;
    bit  acc;
    bit  found;
    int  w;
    for (int i = 0; i < NC; i++) n[i] = mq[i].size();
    legalc = (c < NC) && (l >= 1) && (l <= MAXLEN);
    acc = 0;
    if (v && legalc) acc = (n[c] < DEPTH);
    m_pause = 0;
    for (int i = 0; i < NC; i++) if (n[i] >= THRESH) m_pause = 1;
    found = 0;
    w = 0;
    for (int k = 1; k <= NC; k++) begin
      if (!found && n[(m_rr + k) % NC] > 0) begin
        found = 1;
        w = (m_rr + k) % NC;
      end
    end
    if ((!m_ov || r) && found) begin
      {m_ol, m_od} = mq[w].pop_front();
      m_ov = 1;
      m_oc = w;
      m_rr = w;
    end else if (r) begin
      m_ov = 0;
    end
    if (acc) mq[c].push_back({l[5:0], d});
    m_drop = v && !acc;
    m_err  = v && !legalc;
  endtask

  task automatic checkOutput();
    checkVal("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      checkVal("out_class", 64'(out_class), 64'(m_oc));
      checkVal("out_len", 64'(out_len), 64'(m_ol));
      checkVal("out_data", out_data, m_od);
    end
    checkVal("tx_pause", 64'(tx_pause), 64'(m_pause));
    checkVal("drop_pulse", 64'(drop_pulse), 64'(m_drop));
    checkVal("err_pulse", 64'(err_pulse), 64'(m_err));
  endtask

  // Called at a falling edge: drive, take one rising edge, sample at the next falling edge.
  task automatic applyStimulus(input logic v, input int c, input int l, input logic [63:0] d, input logic r);
    rx_valid  = v;
    rx_class  = c[1:0];
    rx_len    = l[5:0];
    rx_data   = d;
    out_ready = r;
    @(posedge clk);
    modelStep(v, c, l, d, r);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    out_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkVal("reset_valid", 64'(out_valid), 64'd0);
    checkVal("reset_pause", 64'(tx_pause), 64'd0);
    checkVal("reset_drop", 64'(drop_pulse), 64'd0);
    checkVal("reset_err", 64'(err_pulse), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{1, 1, 8, 64'h0123456789ABCDEF, 1, 0, 0, 0, 64'h0, 0, 0};
    tbl[1] = '{0, 0, 0, 64'h0, 1, 1, 1, 8, 64'h0123456789ABCDEF, 0, 0};
    tbl[2] = '{0, 0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 0, 0};
    tbl[3] = '{1, 3, 4, 64'hAA, 1, 0, 0, 0, 64'h0, 1, 1};
    tbl[4] = '{1, 0, 0, 64'hBB, 1, 0, 0, 0, 64'h0, 1, 1};
    tbl[5] = '{1, 2, 9, 64'hCC, 1, 0, 0, 0, 64'h0, 1, 1};
    tbl[6] = '{1, 0, 1, 64'h5A, 1, 0, 0, 0, 64'h0, 0, 0};
    tbl[7] = '{0, 0, 0, 64'h0, 1, 1, 0, 1, 64'h5A, 0, 0};
    tbl[8] = '{0, 0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 0, 0};
    rrExp = '{IPG_CLS_WREQ, IPG_CLS_RRESP, IPG_CLS_RREQ, IPG_CLS_WREQ, IPG_CLS_RRESP};

    @(negedge clk);
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].d, tbl[i].r);
      checkVal("tbl_valid", 64'(out_valid), 64'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        checkVal("tbl_class", 64'(out_class), 64'(tbl[i].e_cls));
        checkVal("tbl_len", 64'(out_len), 64'(tbl[i].e_len));
        checkVal("tbl_data", out_data, tbl[i].e_data);
      end
      checkVal("tbl_drop", 64'(drop_pulse), 64'(tbl[i].e_drop));
      checkVal("tbl_err", 64'(err_pulse), 64'(tbl[i].e_err));
    end

    // Fill class 0 with the output stalled, overflow once, then drain in order.
    doReset();
    for (int k = 1; k <= 9; k++) applyStimulus(1, IPG_CLS_RREQ, 8, 64'(k), 0);
    checkVal("fill_head", out_data, 64'd1);
    checkVal("fill_pause", 64'(tx_pause), 64'd1);
    applyStimulus(1, IPG_CLS_RREQ, 8, 64'd10, 0);
    checkVal("full_drop", 64'(drop_pulse), 64'd1);
    checkVal("full_no_err", 64'(err_pulse), 64'd0);
    for (int k = 2; k <= 9; k++) begin
      applyStimulus(0, 0, 0, 64'd0, 1);
      checkVal("drain_order", out_data, 64'(k));
    end
    checkVal("drain_pause", 64'(tx_pause), 64'd0);
    applyStimulus(0, 0, 0, 64'd0, 1);
    checkVal("drain_empty", 64'(out_valid), 64'd0);

    // Two chunks per class preloaded behind a stalled output, then released.
    doReset();
    for (int c = 0; c < NC; c++) begin
      applyStimulus(1, c, 4, 64'(16 * c), 0);
      applyStimulus(1, c, 4, 64'(16 * c + 1), 0);
    end
    checkVal("rr_first", 64'(out_class), 64'(IPG_CLS_RREQ));
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 64'd0, 1);
      checkVal("rr_order", 64'(out_class), 64'(rrExp[k]));
    end
    applyStimulus(0, 0, 0, 64'd0, 1);
    checkVal("rr_done", 64'(out_valid), 64'd0);

    // Asynchronous reset while a chunk is held and FIFOs are partly full.
    doReset();
    applyStimulus(1, 1, 8, 64'hA1, 0);
    applyStimulus(1, 2, 8, 64'hA2, 0);
    applyStimulus(1, 1, 8, 64'hA3, 0);
    checkVal("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 checkVal("async_rst_valid", 64'(out_valid), 64'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 2, 8, 64'hB2, 1);
    applyStimulus(0, 0, 0, 64'd0, 1);
    checkVal("post_rst_data", out_data, 64'hB2);
    checkVal("post_rst_class", 64'(out_class), 64'd2);
    applyStimulus(0, 0, 0, 64'd0, 1);
    checkVal("post_rst_alone", 64'(out_valid), 64'd0);

    // Randomized traffic with alternating backpressure phases.
    doReset();
    for (int i = 0; i < 1500; i++) begin
      logic v;
      logic r;
      int   c;
      int   l;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      l = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 8));
      if (((i / 150) % 2) == 0) r = ($urandom_range(0, 3) == 0);
      else r = ($urandom_range(0, 3) != 0);
      applyStimulus(v, c, l, {$urandom, $urandom}, r);
    end

`ifdef IPG_DISP_STATS_EN
    doReset();
    for (int k = 0; k < 9; k++) applyStimulus(1, IPG_CLS_RRESP, 8, 64'(k), 0);
    checkVal("stat_accept", 64'(stat_accept[47:32]), 64'd9);
    for (int k = 0; k < 70000; k++) applyStimulus(1, IPG_CLS_RRESP, 8, 64'd0, 0);
    checkVal("stat_drop_sat", 64'(stat_drop[47:32]), 64'hFFFF);
    checkVal("stat_drop_cls0", 64'(stat_drop[15:0]), 64'd0);
    checkVal("stat_err", 64'(stat_err), 64'd0);
    stat_clr = 1'b1;
    applyStimulus(1, IPG_CLS_RRESP, 8, 64'd0, 0);
    stat_clr = 1'b0;
    checkVal("stat_clr_drop", 64'(stat_drop[47:32]), 64'd0);
    checkVal("stat_clr_accept", 64'(stat_accept[47:32]), 64'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
